// File: rtl/morse_decoder_if.sv
// Bit-stream and result signals between a Morse source/monitor and the decoder.
// The decoder takes the slave side and drives the result fields.
interface morse_decoder_if;
  logic        start;
  logic        dot_dash;
  logic        new_bit;
  logic [2:0]  letter;
  logic        letter_valid;
  logic        code_error;
  logic        busy;
  logic [11:0] code;

  modport master (
    output start, dot_dash, new_bit,
    input  letter, letter_valid, code_error, busy, code
  );

  modport slave (
    input  start, dot_dash, new_bit,
    output letter, letter_valid, code_error, busy, code
  );
endinterface

// File: rtl/morse_decoder.sv
// Serial Morse receiver: collects 12 strobed dot/dash bits, matches them
// against the A-H code set and reports the letter index or an error pulse.
module morse_decoder #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  morse_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DECODE  = 2'd2
  } state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [11:0] sr_q;
  logic [3:0]  cnt_q;
  logic [31:0] to_q;
  logic [2:0]  letter_q;
  logic        letter_valid_q;
  logic        code_error_q;
  logic        busy_q;
  logic [11:0] code_q;

  logic [11:0] sr_d;
  logic [3:0]  cnt_d;
  logic [3:0]  match_s;

  // Returns {hit, index}; hit is 0 when the pattern is not one of A-H.
  function automatic logic [3:0] match_letter(input logic [11:0] pat);
    logic [3:0] res;
    case (pat)
      12'b101110000000: res = {1'b1, 3'd0};
      12'b111010101000: res = {1'b1, 3'd1};
      12'b111010111010: res = {1'b1, 3'd2};
      12'b111010100000: res = {1'b1, 3'd3};
      12'b100000000000: res = {1'b1, 3'd4};
      12'b101011101000: res = {1'b1, 3'd5};
      12'b111011101000: res = {1'b1, 3'd6};
      12'b101010100000: res = {1'b1, 3'd7};
      default:          res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  assign sr_d    = {sr_q[10:0], bus.dot_dash};
  assign cnt_d   = cnt_q + 4'd1;
  assign match_s = match_letter(sr_q);

  // Frame FSM with registered result outputs; Start overrides everything but reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      sr_q           <= 12'd0;
      cnt_q          <= 4'd0;
      to_q           <= 32'd0;
      letter_q       <= 3'd0;
      letter_valid_q <= 1'b0;
      code_error_q   <= 1'b0;
      busy_q         <= 1'b0;
      code_q         <= 12'd0;
    end else begin
      letter_valid_q <= 1'b0;
      code_error_q   <= 1'b0;
      if (bus.start) begin
        sr_q    <= 12'd0;
        cnt_q   <= 4'd0;
        to_q    <= 32'd0;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.new_bit) begin
              sr_q    <= sr_d;
              cnt_q   <= 4'd1;
              to_q    <= 32'd0;
              state_q <= ST_RECEIVE;
              busy_q  <= 1'b1;
            end
          end
          ST_RECEIVE: begin
            // A strobe on the last allowed cycle wins over the timeout.
            if (bus.new_bit) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
              to_q  <= 32'd0;
              if (cnt_d == 4'd12) begin
                state_q <= ST_DECODE;
              end
            end else if (to_q == TO_LAST) begin
              code_error_q <= 1'b1;
              sr_q         <= 12'd0;
              cnt_q        <= 4'd0;
              to_q         <= 32'd0;
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
            end else begin
              to_q <= to_q + 32'd1;
            end
          end
          ST_DECODE: begin
            code_q <= sr_q;
            if (match_s[3]) begin
              letter_q       <= match_s[2:0];
              letter_valid_q <= 1'b1;
            end else begin
              code_error_q <= 1'b1;
            end
            // A strobe here already belongs to the next frame.
            to_q <= 32'd0;
            if (bus.new_bit) begin
              sr_q    <= sr_d;
              cnt_q   <= 4'd1;
              state_q <= ST_RECEIVE;
              busy_q  <= 1'b1;
            end else begin
              cnt_q   <= 4'd0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            sr_q    <= 12'd0;
            cnt_q   <= 4'd0;
            to_q    <= 32'd0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.letter       = letter_q;
  assign bus.letter_valid = letter_valid_q;
  assign bus.code_error   = code_error_q;
  assign bus.busy         = busy_q;
  assign bus.code         = code_q;

endmodule
